truth_table_checker: RTL and testbench

TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

---
 rtl/ttc_pkg.sv | 19 +
 rtl/ttc_settle_timer.sv | 30 +++
 rtl/truth_table_checker.sv | 158 +++++++++++++++
 tb/tb_truth_table_checker.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/ttc_pkg.sv
// Shared types and helpers for the truth-table checker: FSM states, vector count,
// and the mapping from vector index to the (x,y,z) stimulus.
package ttc_pkg;

  localparam int NUM_VECTORS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } ttc_state_e;

  // y is the LSB, so the sweep walks y fastest, then x, then z
  function automatic logic [2:0] vec_xyz(input logic [2:0] idx);
    return {idx[1], idx[0], idx[2]};
  endfunction

endpackage

// File: rtl/ttc_settle_timer.sv
// Loadable down-counter; tc flags zero so the FSM knows the stimulus has settled.
module ttc_settle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (en && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps all 8 input vectors of a 3-input function and compares its response to a
// captured expected mask. Define TTC_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module truth_table_checker
  import ttc_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] exp_mask,
  input  logic       s,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] mismatch_mask
`ifdef TTC_STOP_ON_FAIL_EN
  ,
  output logic [2:0] fail_index
`endif
);

  ttc_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] xyz_q, xyz_d;
  logic [7:0] exp_q, exp_d;
  logic [3:0] err_q, err_d;
  logic [7:0] mm_q, mm_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tmr_load, tmr_en, tmr_tc, mis;
`ifdef TTC_STOP_ON_FAIL_EN
  logic [2:0] fail_q, fail_d;
`endif

  ttc_settle_timer #(.WIDTH(4)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (4'(SETTLE_CYCLES - 1)),
    .tc       (tmr_tc)
  );

  assign mis = s ^ exp_q[idx_q];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    xyz_d    = xyz_q;
    exp_d    = exp_q;
    err_d    = err_q;
    mm_d     = mm_q;
    pass_d   = pass_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
`ifdef TTC_STOP_ON_FAIL_EN
    fail_d   = fail_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        exp_d    = exp_mask;
        idx_d    = 3'd0;
        xyz_d    = vec_xyz(3'd0);
        err_d    = 4'd0;
        mm_d     = 8'd0;
        pass_d   = 1'b0;
        busy_d   = 1'b1;
        tmr_load = 1'b1;
`ifdef TTC_STOP_ON_FAIL_EN
        fail_d   = 3'd0;
`endif
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (tmr_tc) state_d = SAMPLE;
        else        tmr_en  = 1'b1;
      end
      SAMPLE: begin
        if (mis) begin
          err_d        = err_q + 4'd1;
          mm_d[idx_q]  = 1'b1;
        end
`ifdef TTC_STOP_ON_FAIL_EN
        if (mis) begin
          fail_d  = idx_q;
          state_d = DONE;
        end else
`endif
        if (idx_q == 3'(NUM_VECTORS - 1)) begin
          state_d = DONE;
        end else begin
          idx_d    = idx_q + 3'd1;
          xyz_d    = vec_xyz(idx_q + 3'd1);
          tmr_load = 1'b1;
          state_d  = SETTLE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_q == 4'd0);
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      xyz_q   <= 3'd0;
      exp_q   <= 8'd0;
      err_q   <= 4'd0;
      mm_q    <= 8'd0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef TTC_STOP_ON_FAIL_EN
      fail_q  <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      xyz_q   <= xyz_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      mm_q    <= mm_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef TTC_STOP_ON_FAIL_EN
      fail_q  <= fail_d;
`endif
    end
  end

  assign x             = xyz_q[2];
  assign y             = xyz_q[1];
  assign z             = xyz_q[0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign mismatch_mask = mm_q;
`ifdef TTC_STOP_ON_FAIL_EN
  assign fail_index    = fail_q;
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker driving s = x & ~(y & z) (or tied 0).
module tb_truth_table_checker;

  localparam int S = 2;
  localparam logic [2:0] EXP_SEQ [8] = '{3'b000, 3'b010, 3'b100, 3'b110,
                                         3'b001, 3'b011, 3'b101, 3'b111};

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, s_zero = 1'b0;
  logic [7:0] exp_mask = 8'h00;
  logic       s, x, y, z, busy, done, pass;
  logic [3:0] err_count;
  logic [7:0] mismatch_mask;
`ifdef TTC_STOP_ON_FAIL_EN
  logic [2:0] fail_index;
`endif
  logic [2:0] seen [8];
  int total = 0, bad = 0, dcyc;

  always #5 clk = ~clk;
  assign s = s_zero ? 1'b0 : (x & ~(y & z));

  truth_table_checker #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_mask(exp_mask), .s(s),
    .x(x), .y(y), .z(z), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .mismatch_mask(mismatch_mask)
`ifdef TTC_STOP_ON_FAIL_EN
    , .fail_index(fail_index)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_xyz"}, {x, y, z}, 3'b000);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_pass"}, pass, 1'b0);
    chk({tag, "_err"}, err_count, 4'd0);
    chk({tag, "_mm"}, mismatch_mask, 8'h00);
`ifdef TTC_STOP_ON_FAIL_EN
    chk({tag, "_fidx"}, fail_index, 3'd0);
`endif
  endtask

  // Returns the cycle (counted from the accept edge) at which done is first seen, or -1.
  task automatic run_sweep(input logic [7:0] em, input int poke_at, input int rst_at,
                           output int dc);
    dc = -1;
    for (int k = 0; k < 8; k++) seen[k] = 3'bxxx;
    @(negedge clk); exp_mask = em; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if ((c + 1) % (S + 1) == 0 && (c + 1) / (S + 1) <= 8)
        seen[(c + 1) / (S + 1) - 1] = {x, y, z};
      if (c == poke_at) begin exp_mask = 8'h00; start = 1'b1; end
      if (c == poke_at + 1) start = 1'b0;
      if (c == rst_at) begin
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midreset");
        @(negedge clk); rst_n = 1'b1;
        return;
      end
      if (done) begin dc = c; break; end
    end
    if (rst_at < 0) chk("done_seen", (dc > 0), 1'b1);
  endtask

  task automatic chk_after_done(input string tag, input logic pass_exp);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_busy_low"}, busy, 1'b0);
    chk({tag, "_xyz_hold"}, {x, y, z}, 3'b111);
    repeat (3) @(posedge clk);
    #1 chk({tag, "_pass_held"}, pass, pass_exp);
  endtask

  task automatic chk_seq(input string tag);
    for (int k = 0; k < 8; k++) chk({tag, "_seq"}, seen[k], EXP_SEQ[k]);
  endtask

  initial begin
    #12 chk_reset_vals("reset");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); chk_reset_vals("post_reset");

    // Matching expected mask
    run_sweep(8'h4C, -1, -1, dcyc);
    chk("t1_done_cyc", dcyc, 25);
    chk("t1_pass", pass, 1'b1);
    chk("t1_err", err_count, 4'd0);
    chk("t1_mm", mismatch_mask, 8'h00);
    chk_seq("t1");
    chk_after_done("t1", 1'b1);

    // Single mismatch on vector 0
    run_sweep(8'h4D, -1, -1, dcyc);
    chk("t2_done_cyc", dcyc, 25);
    chk("t2_pass", pass, 1'b0);
    chk("t2_err", err_count, 4'd1);
    chk("t2_mm", mismatch_mask, 8'h01);
    chk_after_done("t2", 1'b0);

    // Every vector mismatches
    s_zero = 1'b1;
    run_sweep(8'hFF, -1, -1, dcyc);
`ifdef TTC_STOP_ON_FAIL_EN
    chk("t3_done_cyc", dcyc, 4);
    chk("t3_err", err_count, 4'd1);
    chk("t3_mm", mismatch_mask, 8'h01);
    chk("t3_fidx", fail_index, 3'd0);
`else
    chk("t3_done_cyc", dcyc, 25);
    chk("t3_err", err_count, 4'd8);
    chk("t3_mm", mismatch_mask, 8'hFF);
`endif
    chk("t3_pass", pass, 1'b0);
    s_zero = 1'b0;

    // Reset during vector 4, then a fresh full sweep
    run_sweep(8'h4C, -1, 13, dcyc);
    chk_reset_vals("after_midreset");
    run_sweep(8'h4C, -1, -1, dcyc);
    chk("t4_done_cyc", dcyc, 25);
    chk("t4_pass", pass, 1'b1);
    chk("t4_err", err_count, 4'd0);
    chk_seq("t4");

    // start and exp_mask change mid-sweep must be ignored
    run_sweep(8'h4C, 10, -1, dcyc);
    chk("t5_done_cyc", dcyc, 25);
    chk("t5_pass", pass, 1'b1);
    chk("t5_err", err_count, 4'd0);
    chk("t5_mm", mismatch_mask, 8'h00);
    chk_after_done("t5", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
